pc_unit: RTL
============

Name: pc_unit

Overview:
- Program-counter stage of the single-cycle CPU; consumes the control unit's s_inc, wesp, push and pop strobes and produces the instruction-memory address.
- Holds the PC register and a hardware return-address LIFO for subroutine call/return.
- Selects next PC from PC+1, jump target (instruction immediate) or popped return address.
- Flags stack depth faults to the I/O/status logic.

Parameters:
- PC_W, 10, program counter / address width in bits.
- DEPTH, 8, return-stack entries (power of two not required, >=2).
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- s_inc  in  1  1 = sequential (PC+1), 0 = take jump_addr.
- jump_addr  in  PC_W  jump/call target from instruction field.
- wesp  in  1  stack write-enable; push/pop only act when wesp=1.
- push  in  1  call: save return address, branch to jump_addr.
- pop  in  1  return: load PC from stack top.
- pc  out  PC_W  current instruction address.
- stk_depth  out  $clog2(DEPTH+1)  valid entries.
- stk_full  out  1  stk_depth==DEPTH.
- stk_empty  out  1  stk_depth==0.
- stk_ovf  out  1  sticky: push attempted while full.
- stk_unf  out  1  sticky: pop attempted while empty.
- stk_err  out  1  sticky: push and pop asserted together with wesp.

Behaviour:
- Reset (reset_n=0 at clk edge): pc=RESET_PC, depth=0, stk_ovf=stk_unf=stk_err=0. Stack RAM not cleared. Reset wins over every other input; mid-call reset discards all entries.
- One-cycle latency: inputs sampled at edge N define pc after edge N. pc is a register output, never combinational from inputs.
- Priority per cycle, highest first:
  1. wesp&push&pop: no stack change, pc<=pc+1, stk_err<=1.
  2. wesp&pop: if not empty, pc<=stack[depth-1], depth-1. If empty, pc<=pc+1, stk_unf<=1. s_inc ignored.
  3. wesp&push: if not full, stack[depth]<=pc+1, depth+1, pc<=jump_addr (s_inc ignored). If full, no write, pc<=pc+1, stk_ovf<=1.
  4. s_inc=0: pc<=jump_addr.
  5. Otherwise: pc<=pc+1.
- push/pop with wesp=0 are ignored entirely.
- Arithmetic: pc+1 is modulo 2^PC_W (all-ones wraps to 0). The stored return address wraps likewise.
- stk_full and stk_empty are combinational from depth. Sticky flags clear only on reset.
- Push and pop back-to-back on consecutive cycles: the pop sees the just-pushed entry (write completes at edge, read is combinational from the top entry).

Optional Feature:
- Macro PC_UNIT_HOLD_EN.
- Defined: extra input hold (1 bit, placed after reset_n). When hold=1, pc, depth, stack and flags all keep their values. Hold has priority below reset and above all other rules. Used by the I/O wait path.
- Undefined: no hold port; behaviour as above.

Decomposition:
- Package pc_pkg:
  - PC_W default constant.
  - Typedef next_sel_t enum {SEL_INC, SEL_JMP, SEL_RET, SEL_HOLD} for the next-PC mux.
  - Typedef pc_t logic [PC_W-1:0].
- Sub-module ret_stack (parameter DEPTH, W): LIFO with push/pop/top/depth/full/empty. pc_unit owns priority decode, PC register and sticky flags.

Test Plan:
- Reset then 4 cycles of s_inc=1 -> pc 0,1,2,3,4. Flags 0, stk_empty=1.
- At pc=5, s_inc=0, jump_addr=0x40 -> next pc=0x40, depth unchanged.
- At pc=0x10, wesp=1, push=1, jump_addr=0x80 -> pc=0x80, depth=1. Then wesp=1, pop=1 -> pc=0x11, depth=0.
- DEPTH=8: 9 calls -> after 8th stk_full=1. 9th: pc=prev+1, stk_ovf=1, depth stays 8. 8 returns unwind in reverse order, then one extra pop -> stk_unf=1, pc increments.
- wesp=1, push=1, pop=1 at pc=0x20 -> pc=0x21, depth unchanged, stk_err=1. Then pc=all-ones with s_inc=1 -> pc=0. Then reset_n=0 mid-sequence with depth=3 -> pc=RESET_PC, depth=0, all flags 0.
- With PC_UNIT_HOLD_EN: hold=1 for 3 cycles with push requested -> pc and depth frozen. Release -> push executes on the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter stage: default address width,
// next-PC mux selector and the PC word type.
package pc_pkg;

    localparam int PC_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        SEL_INC,
        SEL_JMP,
        SEL_RET,
        SEL_HOLD
    } next_sel_t;

    typedef logic [PC_W_DEFAULT-1:0] pc_t;

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO. Push and pop must be mutually exclusive and are
// ignored when full or empty respectively. Storage is not cleared by reset.
module ret_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 10,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  top_o,
    output logic [DW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    // Index wraps harmlessly at the extremes; gated by full/empty below.
    assign wr_idx = AW'(depth_q);
    assign rd_idx = AW'(depth_q - 1'b1);
    assign top_o  = mem_q[rd_idx];

    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && push_i && !full_o) begin
            mem_q[wr_idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with hardware return-address stack and sticky fault flags.
// Optional PC_UNIT_HOLD_EN adds a 'hold' input that freezes all state.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
`ifdef PC_UNIT_HOLD_EN
    input  logic                       hold,
`endif
    input  logic                       s_inc,
    input  logic [PC_W-1:0]            jump_addr,
    input  logic                       wesp,
    input  logic                       push,
    input  logic                       pop,
    output logic [PC_W-1:0]            pc,
    output logic [$clog2(DEPTH+1)-1:0] stk_depth,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       stk_ovf,
    output logic                       stk_unf,
    output logic                       stk_err
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stk_top;
    logic            ovf_q;
    logic            unf_q;
    logic            err_q;
    logic            set_ovf;
    logic            set_unf;
    logic            set_err;
    logic            stk_push;
    logic            stk_pop;
    logic            hold_act;
    next_sel_t       sel;

`ifdef PC_UNIT_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    assign pc_inc = pc_q + PC_W'(1);

    // Priority: hold, push+pop error, pop, push, jump, increment.
    always_comb begin
        sel      = SEL_INC;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        set_err  = 1'b0;
        if (hold_act) begin
            sel = SEL_HOLD;
        end else if (wesp && push && pop) begin
            set_err = 1'b1;
        end else if (wesp && pop) begin
            if (!stk_empty) begin
                sel     = SEL_RET;
                stk_pop = 1'b1;
            end else begin
                set_unf = 1'b1;
            end
        end else if (wesp && push) begin
            if (!stk_full) begin
                sel      = SEL_JMP;
                stk_push = 1'b1;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (!s_inc) begin
            sel = SEL_JMP;
        end
    end

    always_comb begin
        case (sel)
            SEL_JMP:  pc_d = jump_addr;
            SEL_RET:  pc_d = stk_top;
            SEL_HOLD: pc_d = pc_q;
            default:  pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_q | set_ovf;
            unf_q <= unf_q | set_unf;
            err_q <= err_q | set_err;
        end
    end

    ret_stack #(
        .DEPTH (DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .wdata_i (pc_inc),
        .top_o   (stk_top),
        .depth_o (stk_depth),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign pc      = pc_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
    assign stk_err = err_q;

endmodule
